// File: rtl/affine_iter_ctrl_pkg.sv
// Shared definitions for the affine iteration controller and its benches:
// FSM state encoding, default word width and a few IEEE-754 constants.
package affine_iter_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } ctrl_state_t;

    // Default width of one single-precision state element
    localparam int PRECISION_DEFAULT = 32;

    // Single-precision constants handy for seeding sequences
    localparam logic [31:0] FP32_ONE   = 32'h3f80_0000;
    localparam logic [31:0] FP32_TWO   = 32'h4000_0000;
    localparam logic [31:0] FP32_THREE = 32'h4040_0000;

endpackage

// File: rtl/affine_iter_ctrl.sv
// Iteration controller for an external affine_transform datapath.
// Repeatedly feeds the current 3-element state to the datapath, captures each
// result as the new state and streams it out with a valid/ready handshake.
// State words are passed through untouched; no arithmetic is done on them.
module affine_iter_ctrl
    import affine_iter_ctrl_pkg::*;
#(
    parameter int PRECISION = PRECISION_DEFAULT,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 start,
    input  logic [CNT_W-1:0]     iter_count,
    input  logic [PRECISION-1:0] seed0,
    input  logic [PRECISION-1:0] seed1,
    input  logic [PRECISION-1:0] seed2,
    output logic                 busy,
    output logic                 done,
    output logic                 error,

    output logic                 dp_tvalid,
    output logic [PRECISION-1:0] dp_x0,
    output logic [PRECISION-1:0] dp_x1,
    output logic [PRECISION-1:0] dp_x2,
    input  logic                 dp_valid,
    input  logic [PRECISION-1:0] dp_x_next0,
    input  logic [PRECISION-1:0] dp_x_next1,
    input  logic [PRECISION-1:0] dp_x_next2,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PRECISION-1:0] out_x0,
    output logic [PRECISION-1:0] out_x1,
    output logic [PRECISION-1:0] out_x2,
    output logic                 out_last
);

    // Wide enough to hold TIMEOUT-1 even for TIMEOUT=1
    localparam int             TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    ctrl_state_t           state_reg;
    logic [PRECISION-1:0]  x0_reg;
    logic [PRECISION-1:0]  x1_reg;
    logic [PRECISION-1:0]  x2_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [TO_W-1:0]       timeout_reg;

    // The datapath always sees the state register; it only changes on a
    // WAIT exit, so it is stable for the whole ISSUE/WAIT window.
    assign dp_x0 = x0_reg;
    assign dp_x1 = x1_reg;
    assign dp_x2 = x2_reg;

    // Sequencing FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            x0_reg      <= '0;
            x1_reg      <= '0;
            x2_reg      <= '0;
            cnt_reg     <= '0;
            timeout_reg <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            dp_tvalid   <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_x0      <= '0;
            out_x1      <= '0;
            out_x2      <= '0;
        end else begin
            // Strobes default low; they are single-cycle by construction
            done      <= 1'b0;
            dp_tvalid <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        x0_reg  <= seed0;
                        x1_reg  <= seed1;
                        x2_reg  <= seed2;
                        cnt_reg <= iter_count;
                        error   <= 1'b0;
                        if (iter_count != '0) begin
                            state_reg <= ST_ISSUE;
                            busy      <= 1'b1;
                            dp_tvalid <= 1'b1;
                        end else begin
                            // Empty sequence completes immediately
                            done <= 1'b1;
                        end
                    end
                end

                ST_ISSUE: begin
                    // dp_tvalid was raised on entry and drops now
                    state_reg   <= ST_WAIT;
                    timeout_reg <= '0;
                end

                ST_WAIT: begin
                    if (dp_valid) begin
                        x0_reg    <= dp_x_next0;
                        x1_reg    <= dp_x_next1;
                        x2_reg    <= dp_x_next2;
                        out_x0    <= dp_x_next0;
                        out_x1    <= dp_x_next1;
                        out_x2    <= dp_x_next2;
                        out_valid <= 1'b1;
                        // The result that consumes the last iteration is final
                        out_last  <= (cnt_reg == CNT_W'(1));
                        if (cnt_reg != '0) begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                        state_reg <= ST_EMIT;
                    end else if (timeout_reg == TO_LAST) begin
                        // Datapath never answered: abandon the sequence
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        timeout_reg <= timeout_reg + TO_W'(1);
                    end
                end

                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (cnt_reg != '0) begin
                            state_reg <= ST_ISSUE;
                            dp_tvalid <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
